// File: rtl/alu_pc.sv
// alu_pc: combinational 8-bit ALU (6502/2A03 style) plus a 16-bit program counter.
// Optional BCD add/subtract is enabled by defining the macro ALU_DECIMAL_EN;
// without it decimal_in is ignored and ADD/SUB are always binary.
module alu_pc #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  alu_a,
  input  logic [7:0]  alu_b,
  input  logic        carry_in,
  input  logic [4:0]  mode,
  input  logic        decimal_in,
  output logic [7:0]  alu_out,
  output logic        carry_out,
  output logic        overflow_out,
  output logic        zero_out,
  output logic        negative_out,
  input  logic [15:0] pc_in,
  input  logic        pc_load,
  input  logic        pc_inc,
  output logic [15:0] pc_out
);

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_EOR    = 5'd4;
  localparam logic [4:0] ALU_ASL    = 5'd5;
  localparam logic [4:0] ALU_LSR    = 5'd6;
  localparam logic [4:0] ALU_ROL    = 5'd7;
  localparam logic [4:0] ALU_ROR    = 5'd8;
  localparam logic [4:0] ALU_INC    = 5'd9;
  localparam logic [4:0] ALU_DEC    = 5'd10;
  localparam logic [4:0] ALU_PASS_B = 5'd11;

  logic [8:0] bin_add;
  logic [8:0] bin_sub;
  logic       add_v;
  logic       sub_v;

  // Binary sums; subtraction is a + ~b + c so carry set means "no borrow".
  assign bin_add = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, carry_in};
  assign bin_sub = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, carry_in};

  // Signed overflow: operands agree in sign but the result does not.
  assign add_v = (alu_a[7] == alu_b[7]) && (bin_add[7] != alu_a[7]);
  assign sub_v = (alu_a[7] != alu_b[7]) && (bin_sub[7] != alu_a[7]);

`ifdef ALU_DECIMAL_EN
  logic [4:0] dadd_lo, dadd_hi, dsub_lo, dsub_hi;
  logic [3:0] dadd_lo_fix, dadd_hi_fix, dsub_lo_fix, dsub_hi_fix;
  logic       dadd_lc, dadd_c, dsub_lc, dsub_c;

  // Per-nibble BCD correction: +6 on digit overflow for add, -6 on nibble borrow for sub.
  always_comb begin
    dadd_lo     = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'd0, carry_in};
    dadd_lc     = (dadd_lo > 5'd9);
    dadd_lo_fix = dadd_lc ? (dadd_lo[3:0] + 4'd6) : dadd_lo[3:0];
    dadd_hi     = {1'b0, alu_a[7:4]} + {1'b0, alu_b[7:4]} + {4'd0, dadd_lc};
    dadd_c      = (dadd_hi > 5'd9);
    dadd_hi_fix = dadd_c ? (dadd_hi[3:0] + 4'd6) : dadd_hi[3:0];
    dsub_lo     = {1'b0, alu_a[3:0]} + {1'b0, ~alu_b[3:0]} + {4'd0, carry_in};
    dsub_lc     = dsub_lo[4];
    dsub_lo_fix = dsub_lc ? dsub_lo[3:0] : (dsub_lo[3:0] - 4'd6);
    dsub_hi     = {1'b0, alu_a[7:4]} + {1'b0, ~alu_b[7:4]} + {4'd0, dsub_lc};
    dsub_c      = dsub_hi[4];
    dsub_hi_fix = dsub_c ? dsub_hi[3:0] : (dsub_hi[3:0] - 4'd6);
  end
`else
  logic unused_decimal;
  assign unused_decimal = decimal_in;
`endif

  // Result and carry select; unlisted modes give zero and pass the carry through.
  always_comb begin
    alu_out      = 8'h00;
    carry_out    = carry_in;
    overflow_out = 1'b0;
    case (mode)
      ALU_ADD: begin
        {carry_out, alu_out} = bin_add;
        overflow_out         = add_v;
`ifdef ALU_DECIMAL_EN
        if (decimal_in) begin
          alu_out   = {dadd_hi_fix, dadd_lo_fix};
          carry_out = dadd_c;
        end
`endif
      end
      ALU_SUB: begin
        {carry_out, alu_out} = bin_sub;
        overflow_out         = sub_v;
`ifdef ALU_DECIMAL_EN
        if (decimal_in) begin
          alu_out   = {dsub_hi_fix, dsub_lo_fix};
          carry_out = dsub_c;
        end
`endif
      end
      ALU_AND:    alu_out = alu_a & alu_b;
      ALU_OR:     alu_out = alu_a | alu_b;
      ALU_EOR:    alu_out = alu_a ^ alu_b;
      ALU_ASL: begin
        alu_out   = {alu_a[6:0], 1'b0};
        carry_out = alu_a[7];
      end
      ALU_LSR: begin
        alu_out   = {1'b0, alu_a[7:1]};
        carry_out = alu_a[0];
      end
      ALU_ROL: begin
        alu_out   = {alu_a[6:0], carry_in};
        carry_out = alu_a[7];
      end
      ALU_ROR: begin
        alu_out   = {carry_in, alu_a[7:1]};
        carry_out = alu_a[0];
      end
      ALU_INC:    alu_out = alu_a + 8'd1;
      ALU_DEC:    alu_out = alu_a - 8'd1;
      ALU_PASS_B: alu_out = alu_b;
      default:    alu_out = 8'h00;
    endcase
  end

  assign zero_out     = (alu_out == 8'h00);
  assign negative_out = alu_out[7];

  // Program counter: load beats increment; reset wins over everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out <= PC_RESET;
    end else if (pc_load) begin
      pc_out <= pc_in;
    end else if (pc_inc) begin
      pc_out <= pc_out + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_pc.sv
// tb_alu_pc: scoreboard bench for alu_pc (ALU vectors plus PC sequencing).
// Expectations for the BCD vectors follow ALU_DECIMAL_EN when it is defined.
module tb_alu_pc;

  typedef struct {
    string      tag;
    logic [7:0] out;
    logic       c, v, z, n;
  } alu_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  alu_a = 8'h00, alu_b = 8'h00;
  logic        carry_in = 1'b0, decimal_in = 1'b0;
  logic [4:0]  mode = 5'd0;
  logic [7:0]  alu_out;
  logic        carry_out, overflow_out, zero_out, negative_out;
  logic [15:0] pc_in = 16'h0000;
  logic        pc_load = 1'b0, pc_inc = 1'b0;
  logic [15:0] pc_out;

  alu_exp_t    alu_q[$];
  logic [15:0] pc_q[$];
  logic [15:0] model_pc;
  int          vectors = 0;
  int          miscompares = 0;

  alu_pc dut (
    .clk(clk), .rst(rst), .alu_a(alu_a), .alu_b(alu_b), .carry_in(carry_in),
    .mode(mode), .decimal_in(decimal_in), .alu_out(alu_out), .carry_out(carry_out),
    .overflow_out(overflow_out), .zero_out(zero_out), .negative_out(negative_out),
    .pc_in(pc_in), .pc_load(pc_load), .pc_inc(pc_inc), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Independent reference built from integer arithmetic.
  function automatic alu_exp_t aluModel(input string tag, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin,
                                        input logic [4:0] m);
    alu_exp_t e;
    int ai = int'(a), bi = int'(b), ci = int'(cin);
    int sa = (ai > 127) ? ai - 256 : ai;
    int sb = (bi > 127) ? bi - 256 : bi;
    int s, r;
    e.tag = tag; e.c = cin; e.v = 1'b0; e.out = 8'h00;
    case (m)
      5'd0: begin
        s = ai + bi + ci; e.out = 8'(s); e.c = (s > 255);
        r = sa + sb + ci; e.v = (r > 127) || (r < -128);
      end
      5'd1: begin
        s = ai - bi - (1 - ci); e.out = 8'(s); e.c = (s >= 0);
        r = sa - sb - (1 - ci); e.v = (r > 127) || (r < -128);
      end
      5'd2: e.out = a & b;
      5'd3: e.out = a | b;
      5'd4: e.out = a ^ b;
      5'd5: begin e.out = 8'((ai * 2) % 256); e.c = (ai >= 128); end
      5'd6: begin e.out = 8'(ai / 2); e.c = (ai % 2 == 1); end
      5'd7: begin e.out = 8'((ai * 2 + ci) % 256); e.c = (ai >= 128); end
      5'd8: begin e.out = 8'(ai / 2 + 128 * ci); e.c = (ai % 2 == 1); end
      5'd9: e.out = 8'((ai + 1) % 256);
      5'd10: e.out = 8'((ai + 255) % 256);
      5'd11: e.out = b;
      default: e.out = 8'h00;
    endcase
    e.z = (e.out == 8'h00);
    e.n = (int'(e.out) >= 128);
    return e;
  endfunction

  function automatic alu_exp_t mkExp(input string tag, input logic [7:0] o,
                                     input logic c, input logic v,
                                     input logic z, input logic n);
    alu_exp_t e;
    e.tag = tag; e.out = o; e.c = c; e.v = v; e.z = z; e.n = n;
    return e;
  endfunction

  // Drive one ALU vector, queue its expectation, then compare once settled.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic [4:0] m,
                               input logic dec, input alu_exp_t e);
    alu_exp_t got;
    alu_a = a; alu_b = b; carry_in = cin; mode = m; decimal_in = dec;
    alu_q.push_back(e);
    #1;
    got = alu_q.pop_front();
    checkOutput({got.tag, ".out"}, 32'(alu_out), 32'(got.out));
    checkOutput({got.tag, ".c"}, 32'(carry_out), 32'(got.c));
    checkOutput({got.tag, ".v"}, 32'(overflow_out), 32'(got.v));
    checkOutput({got.tag, ".z"}, 32'(zero_out), 32'(got.z));
    checkOutput({got.tag, ".n"}, 32'(negative_out), 32'(got.n));
  endtask

  // One PC clock: drive on the falling edge, compare just after the rising edge.
  task automatic pcStep(input string tag, input logic ld, input logic inc,
                        input logic [15:0] din);
    @(negedge clk);
    pc_load = ld; pc_inc = inc; pc_in = din;
    if (ld) model_pc = din;
    else if (inc) model_pc = model_pc + 16'd1;
    pc_q.push_back(model_pc);
    @(posedge clk);
    #1;
    checkOutput(tag, 32'(pc_out), 32'(pc_q.pop_front()));
  endtask

  initial begin
    alu_exp_t e;
    logic [7:0] ra, rb;
    logic rc;
    logic [4:0] rm;

    // Reset asserted across a clock edge with load requested.
    #1 rst = 1'b1;
    pc_load = 1'b1; pc_in = 16'h5555;
    #11;
    checkOutput("rst_hold", 32'(pc_out), 32'h0000);
    model_pc = 16'h0000;

    // Directed ALU vectors, checked while reset is still asserted.
    applyStimulus(8'h50, 8'h50, 1'b0, 5'd0, 1'b0, mkExp("add50", 8'hA0, 0, 1, 0, 1));
    @(negedge clk);
    rst = 1'b0; pc_load = 1'b0;
    applyStimulus(8'h00, 8'h01, 1'b1, 5'd1, 1'b0, mkExp("sub0-1", 8'hFF, 0, 0, 0, 1));
    applyStimulus(8'h05, 8'h05, 1'b1, 5'd1, 1'b0, mkExp("sub5-5", 8'h00, 1, 0, 1, 0));
    applyStimulus(8'h81, 8'h00, 1'b0, 5'd5, 1'b0, mkExp("asl81", 8'h02, 1, 0, 0, 0));
    applyStimulus(8'h01, 8'h00, 1'b1, 5'd8, 1'b0, mkExp("ror01", 8'h80, 1, 0, 0, 1));
    applyStimulus(8'hFF, 8'h00, 1'b1, 5'd9, 1'b0, mkExp("incFF", 8'h00, 1, 0, 1, 0));
    applyStimulus(8'h00, 8'h00, 1'b0, 5'd10, 1'b0, mkExp("dec00", 8'hFF, 0, 0, 0, 1));
    applyStimulus(8'h12, 8'h9C, 1'b1, 5'd11, 1'b0, mkExp("passb", 8'h9C, 1, 0, 0, 1));
    applyStimulus(8'hAA, 8'h55, 1'b1, 5'd20, 1'b0, mkExp("mode20", 8'h00, 1, 0, 1, 0));
`ifdef ALU_DECIMAL_EN
    applyStimulus(8'h19, 8'h28, 1'b0, 5'd0, 1'b1, mkExp("bcd19+28", 8'h47, 0, 0, 0, 0));
    applyStimulus(8'h99, 8'h01, 1'b0, 5'd0, 1'b1, mkExp("bcd99+01", 8'h00, 1, 0, 1, 0));
`else
    applyStimulus(8'h19, 8'h28, 1'b0, 5'd0, 1'b1, mkExp("bcd19+28", 8'h41, 0, 0, 0, 0));
    applyStimulus(8'h99, 8'h01, 1'b0, 5'd0, 1'b1, mkExp("bcd99+01", 8'h9A, 0, 0, 0, 1));
`endif

    // Random binary vectors across every mode.
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rm = 5'($urandom_range(0, 31));
      e = aluModel($sformatf("rnd%0d_m%0d", i, rm), ra, rb, rc, rm);
      applyStimulus(ra, rb, rc, rm, 1'b0, e);
    end

    // PC: load, then reset mid-cycle with an increment pending.
    pcStep("pc_ld1234", 1'b1, 1'b0, 16'h1234);
    pc_load = 1'b0; pc_inc = 1'b1;
    #2 rst = 1'b1;
    #1 checkOutput("pc_async_rst", 32'(pc_out), 32'h0000);
    @(posedge clk);
    #1 checkOutput("pc_rst_held", 32'(pc_out), 32'h0000);
    model_pc = 16'h0000;
    @(negedge clk);
    rst = 1'b0; pc_inc = 1'b0;

    pcStep("pc_ld8000", 1'b1, 1'b0, 16'h8000);
    for (int i = 0; i < 3; i++) pcStep($sformatf("pc_inc%0d", i), 1'b0, 1'b1, 16'h0000);
    checkOutput("pc_8003", 32'(pc_out), 32'h8003);
    pcStep("pc_ldFFFF", 1'b1, 1'b0, 16'hFFFF);
    pcStep("pc_wrap", 1'b0, 1'b1, 16'h0000);
    pcStep("pc_ld_and_inc", 1'b1, 1'b1, 16'h4000);
    pcStep("pc_hold", 1'b0, 1'b0, 16'h7777);
    for (int i = 0; i < 20; i++)
      pcStep($sformatf("pc_rnd%0d", i), 1'($urandom_range(0, 3) == 0), 1'($urandom),
             16'($urandom));

    if (alu_q.size() != 0 || pc_q.size() != 0)
      checkOutput("queues_empty", 32'(alu_q.size() + pc_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
